// File: rtl/lcd_timing_gen_if.sv
// Pixel-request, control and RGB565 panel signals of the LCD timing generator.
// master = timing generator, slave = framebuffer reader / panel side.
interface lcd_timing_gen_if #(
    parameter int XW = 11,
    parameter int YW = 10
);
    logic          enable;
    logic [1:0]    pattern_sel;
    logic          req_valid;
    logic [XW-1:0] req_x;
    logic [YW-1:0] req_y;
    logic [23:0]   rgb_in;
    logic          line_start;
    logic          frame_start;
    logic          LCD_DE;
    logic          LCD_HSYNC;
    logic          LCD_VSYNC;
    logic [4:0]    LCD_R;
    logic [5:0]    LCD_G;
    logic [4:0]    LCD_B;

    modport master (
        input  enable, pattern_sel, rgb_in,
        output req_valid, req_x, req_y, line_start, frame_start,
               LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B
    );

    modport slave (
        output enable, pattern_sel, rgb_in,
        input  req_valid, req_x, req_y, line_start, frame_start,
               LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B
    );
endinterface

// File: rtl/lcd_timing_gen.sv
// Parametrised RGB panel timing generator with lead-ahead pixel requests and test patterns.
// req_* 1 cycle after counters, LCD_* exactly LEAD+1 after req_*; free-running, no backpressure.
module lcd_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 210,
    parameter int H_SYNC   = 1,
    parameter int H_BP     = 182,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 45,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 0,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int LEAD     = 4,
    parameter int XW       = 11,
    parameter int YW       = 10
) (
    input  logic              PixelClk,
    input  logic              nRST,
    lcd_timing_gen_if.master  bus
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [XW-1:0] H_ACT_C  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] H_SS_C   = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] H_SE_C   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XW-1:0] H_LAST_C = XW'(H_TOT - 1);
    localparam logic [YW-1:0] V_ACT_C  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] V_SS_C   = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] V_SE_C   = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [YW-1:0] V_LAST_C = YW'(V_TOT - 1);

    logic [XW-1:0] h_q, h_d;
    logic [YW-1:0] v_q, v_d;
    logic          act_d, line_start_d, frame_start_d, hs_d, vs_d;

    logic          req_valid_q, line_start_q, frame_start_q, hs_req_q, vs_req_q;
    logic [XW-1:0] req_x_q;
    logic [YW-1:0] req_y_q;
    logic [1:0]    pat_sel_q;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (!bus.enable) begin
            h_d = '0;
            v_d = '0;
        end else if (h_q == H_LAST_C) begin
            h_d = '0;
            v_d = (v_q == V_LAST_C) ? '0 : v_q + 1'b1;
        end else begin
            h_d = h_q + 1'b1;
        end
        act_d         = bus.enable && (h_q < H_ACT_C) && (v_q < V_ACT_C);
        line_start_d  = bus.enable && (h_q == '0) && (v_q < V_ACT_C);
        frame_start_d = bus.enable && (h_q == '0) && (v_q == '0);
        hs_d          = bus.enable && (h_q >= H_SS_C) && (h_q < H_SE_C);
        vs_d          = bus.enable && (v_q >= V_SS_C) && (v_q < V_SE_C);
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            h_q           <= '0;
            v_q           <= '0;
            req_valid_q   <= 1'b0;
            req_x_q       <= '0;
            req_y_q       <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            hs_req_q      <= 1'b0;
            vs_req_q      <= 1'b0;
            pat_sel_q     <= 2'd0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            req_valid_q   <= act_d;
            req_x_q       <= act_d ? h_q : '0;
            req_y_q       <= act_d ? v_q : '0;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            hs_req_q      <= hs_d;
            vs_req_q      <= vs_d;
            // Pattern changes only take effect on a frame boundary.
            if (frame_start_d) pat_sel_q <= bus.pattern_sel;
        end
    end

    logic [2:0]  bar_idx;
    logic [4:0]  grad_r;
    logic [15:0] pat_d;

    always_comb begin
        bar_idx = 3'((32'(req_x_q) << 3) / 32'(H_ACTIVE));
        grad_r  = req_x_q[XW-1 -: 5];
        case (pat_sel_q)
            2'd1:    pat_d = {{5{bar_idx[2]}}, {6{bar_idx[1]}}, {5{bar_idx[0]}}};
            2'd2:    pat_d = ((req_x_q[4:0] == 5'd0) || (req_y_q[4:0] == 5'd0)) ? 16'hFFFF : 16'h0000;
            2'd3:    pat_d = {grad_r, req_y_q[YW-1 -: 6], 5'h1F - grad_r};
            default: pat_d = 16'h0000;
        endcase
    end

    // Everything derived from the request stage travels LEAD cycles so it meets rgb_in.
    logic [LEAD-1:0] act_dl_q, hs_dl_q, vs_dl_q;
    logic [1:0]      sel_dl_q [LEAD];
    logic [15:0]     pat_dl_q [LEAD];

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            act_dl_q <= '0;
            hs_dl_q  <= '0;
            vs_dl_q  <= '0;
            for (int i = 0; i < LEAD; i++) begin
                sel_dl_q[i] <= 2'd0;
                pat_dl_q[i] <= 16'h0000;
            end
        end else begin
            act_dl_q[0] <= req_valid_q;
            hs_dl_q[0]  <= hs_req_q;
            vs_dl_q[0]  <= vs_req_q;
            sel_dl_q[0] <= pat_sel_q;
            pat_dl_q[0] <= pat_d;
            for (int i = 1; i < LEAD; i++) begin
                act_dl_q[i] <= act_dl_q[i-1];
                hs_dl_q[i]  <= hs_dl_q[i-1];
                vs_dl_q[i]  <= vs_dl_q[i-1];
                sel_dl_q[i] <= sel_dl_q[i-1];
                pat_dl_q[i] <= pat_dl_q[i-1];
            end
        end
    end

    logic        de_q, hsync_q, vsync_q;
    logic [15:0] pix_q, pix_d;
    logic        unused_rgb;

    assign unused_rgb = ^{bus.rgb_in[18:16], bus.rgb_in[9:8], bus.rgb_in[2:0]};

    always_comb begin
        pix_d = 16'h0000;
        if (act_dl_q[LEAD-1]) begin
            pix_d = (sel_dl_q[LEAD-1] == 2'd0)
                  ? {bus.rgb_in[23:19], bus.rgb_in[15:10], bus.rgb_in[7:3]}
                  : pat_dl_q[LEAD-1];
        end
    end

    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            de_q    <= 1'b0;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            pix_q   <= 16'h0000;
        end else begin
            de_q    <= act_dl_q[LEAD-1];
            hsync_q <= hs_dl_q[LEAD-1] ? HS_POL : ~HS_POL;
            vsync_q <= vs_dl_q[LEAD-1] ? VS_POL : ~VS_POL;
            pix_q   <= pix_d;
        end
    end

    assign bus.req_valid   = req_valid_q;
    assign bus.req_x       = req_x_q;
    assign bus.req_y       = req_y_q;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;
    assign bus.LCD_DE      = de_q;
    assign bus.LCD_HSYNC   = hsync_q;
    assign bus.LCD_VSYNC   = vsync_q;
    assign bus.LCD_R       = pix_q[15:11];
    assign bus.LCD_G       = pix_q[10:5];
    assign bus.LCD_B       = pix_q[4:0];
endmodule
